// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the fetch PC, issues one imem request at a
// time over req/gnt/rvalid, and registers the IF/ID word consumed by decode.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus_4_d,
    output logic        valid_d
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_f;
    logic [31:0] pc_f_plus_4;
    logic [31:0] skid;
    logic        deliver;
    logic        skid_load;
    logic [31:0] deliver_instr;

    assign pc_f_plus_4   = pc_f + 32'd4;
    assign imem_req      = (state == S_REQ);
    assign imem_addr     = pc_f;
    assign deliver_instr = (state == S_HOLD) ? skid : imem_rdata;

    // A redirect always wins: the in-flight or buffered instruction is never delivered.
    always_comb begin
        state_n   = state;
        deliver   = 1'b0;
        skid_load = 1'b0;
        case (state)
            S_REQ: begin
                if (imem_gnt)
                    state_n = pc_src_e ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (pc_src_e) begin
                    state_n = imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem_rvalid) begin
                    if (stall_f) begin
                        state_n   = S_HOLD;
                        skid_load = 1'b1;
                    end else begin
                        state_n = S_REQ;
                        deliver = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (pc_src_e) begin
                    state_n = S_REQ;
                end else if (!stall_f) begin
                    state_n = S_REQ;
                    deliver = 1'b1;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid)
                    state_n = S_REQ;
            end
            default: state_n = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_REQ;
            pc_f  <= RESET_PC;
            skid  <= '0;
        end else begin
            state <= state_n;
            if (pc_src_e)
                pc_f <= {pc_target_e[31:2], 2'b00};
            else if (deliver)
                pc_f <= pc_f_plus_4;
            if (skid_load)
                skid <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_d) begin
            instr_d     <= NOP_INSTR;
            pc_d        <= '0;
            pc_plus_4_d <= '0;
            valid_d     <= 1'b0;
        end else if (stall_f) begin
            instr_d     <= instr_d;
            pc_d        <= pc_d;
            pc_plus_4_d <= pc_plus_4_d;
            valid_d     <= valid_d;
        end else if (deliver) begin
            instr_d     <= deliver_instr;
            pc_d        <= pc_f;
            pc_plus_4_d <= pc_f_plus_4;
            valid_d     <= 1'b1;
        end else begin
            instr_d     <= NOP_INSTR;
            pc_d        <= '0;
            pc_plus_4_d <= '0;
            valid_d     <= 1'b0;
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; sits directly upstream of the decode stage.
- Owns the fetch PC and issues one instruction-memory request at a time over a req/gnt/rvalid handshake.
- Registers the IF/ID pipeline word (instruction, pc, pc+4, valid) consumed by decode.
- Honours hazard-unit stall/flush and EX-stage branch/jump redirects.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
stall_f  input  1  hold PC and IF/ID contents
flush_d  input  1  replace IF/ID contents with bubble
pc_src_e  input  1  redirect fetch (taken branch/jump resolved in EX)
pc_target_e  input  32  redirect target
imem_req  output  1  fetch request
imem_addr  output  32  fetch address (word aligned)
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  32  fetched instruction
instr_d  output  32  IF/ID instruction
pc_d  output  32  IF/ID pc
pc_plus_4_d  output  32  IF/ID pc+4
valid_d  output  1  IF/ID holds a real instruction

Behaviour:
- Clock/reset: single clock clk; reset is synchronous and active-high. All state updates on rising edge of clk.
- Reset values: pc_f=RESET_PC, state=REQ, buffer empty, instr_d=NOP_INSTR, pc_d=0, pc_plus_4_d=0, valid_d=0. imem_req=1 with imem_addr=RESET_PC in the first cycle after reset deasserts.
- FSM states: REQ, WAIT, DRAIN, HOLD.
- REQ:
  - imem_req=1, imem_addr=pc_f.
  - Address stays stable until imem_gnt; the only exception is a redirect, where the address changes to the target on the next cycle.
  - On gnt, go to WAIT.
- WAIT:
  - imem_req=0. Exactly one request is outstanding. Await imem_rvalid.
  - On rvalid with stall_f=0: load IF/ID with {imem_rdata, pc_f, pc_f+4, valid=1}, set pc_f<=pc_f+4, go to REQ.
  - On rvalid with stall_f=1: capture rdata in the skid buffer, leave IF/ID unchanged, go to HOLD.
- HOLD:
  - imem_req=0.
  - When stall_f=0: load IF/ID from the buffer (valid=1), set pc_f<=pc_f+4, go to REQ.
- DRAIN:
  - imem_req=0. Discard the next rvalid (stale fetch), then go to REQ with the already-updated pc_f.
- Redirect (pc_src_e=1), highest priority for pc_f:
  - pc_f<=pc_target_e with bits [1:0] forced to 0.
  - The buffered instruction is discarded.
  - REQ with gnt this cycle goes to DRAIN; REQ without gnt stays REQ.
  - WAIT without rvalid goes to DRAIN; WAIT with rvalid drops the response and goes to REQ.
  - HOLD goes to REQ.
  - The response is never written to IF/ID in any of these cases.
  - Redirect does not itself clear IF/ID; the hazard unit asserts flush_d.
- IF/ID update priority: flush_d > stall_f > delivery > bubble.
  - flush_d: {NOP_INSTR, 0, 0, valid=0}, regardless of stall_f.
  - stall_f (no flush): hold all IF/ID outputs.
  - No instruction delivered and no stall: bubble {NOP_INSTR, 0, 0, valid=0}.
- flush_d does not affect the FSM or pc_f.
- Widths: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Spurious imem_rvalid in REQ or HOLD is ignored.
- imem_gnt outside REQ is ignored.
- Reset mid-transaction abandons the outstanding fetch. The memory is reset on the same reset, so no stale response is expected.
- Throughput: one instruction per 2 cycles minimum with single-cycle gnt/rvalid (one outstanding request).

Test Plan:
- Reset then zero-wait memory returning 32'h00500093 @0, 32'h00100113 @4 -> imem_addr 0,4,8; IF/ID shows instr 00500093/pc 0/pc+4 4 with valid=1, then 00100113/pc 4/pc+4 8; bubble (NOP, valid=0) cycles in between.
- stall_f held 3 cycles while rvalid arrives for pc 8 -> IF/ID unchanged, state HOLD, no new req; on release IF/ID = {rdata, 8, 12, 1} and next req addr 12.
- pc_src_e=1, target 32'h0000_0102, asserted while in WAIT for pc 16 -> response for 16 dropped (DRAIN); next imem_addr = 32'h0000_0100.
- flush_d and stall_f both high with valid IF/ID contents -> IF/ID = {00000013, 0, 0, 0}; pc_f unchanged.
- imem_gnt withheld 4 cycles -> imem_req stays 1 with constant imem_addr; gnt on cycle 5 -> WAIT; spurious rvalid in REQ produces no IF/ID change.
- pc_f = 32'hFFFF_FFFC fetch -> pc_plus_4_d = 0, next imem_addr = 0; reset asserted in WAIT -> next cycle imem_addr = RESET_PC, valid_d = 0.
